pipe_stage_elastic: RTL and testbench

PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_slot.sv | 46 ++++
 rtl/pipe_stage_elastic.sv | 141 ++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage.
//   WORD_W        : width of one datapath word
//   DEF_NUM_WORDS : default number of datapath words per entry
//   DEF_CTRL_W    : default width of the control bundle
//   state_e       : occupancy state; the encoding equals the entry count
package pipe_pkg;

  localparam int WORD_W        = 32;
  localparam int DEF_NUM_WORDS = 5;
  localparam int DEF_CTRL_W    = 9;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the elastic stage: a load-enable register that can be
// cleared synchronously. Clear has priority over load.
//   clk_i, rst_n_i : clock, asynchronous active-low reset (clears contents)
//   load_i         : capture d_i on the next rising edge
//   clr_i          : zero the contents on the next rising edge
//   d_i / q_o      : entry in / held entry out
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int W = WORD_W * DEF_NUM_WORDS + DEF_CTRL_W
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  // next slot contents: clear beats load, otherwise hold
  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (load_i) begin
      data_d = d_i;
    end else begin
      data_d = data_q;
    end
  end

  // slot register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Two-entry elastic pipeline stage (main slot + skid slot).
// The main slot always drives the outputs; the skid slot catches the one
// entry that arrives while downstream stalls, since in_ready_o is registered
// and cannot drop in the same cycle out_ready_i falls.
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   flush_i                 : discard everything held and presented this cycle
//   in_valid_i / in_ready_o : upstream handshake (in_ready_o is a flop)
//   in_data_i, in_ctrl_i    : upstream payload, word 0 in bits 31:0
//   out_valid_o/out_ready_i : downstream handshake
//   out_data_o, out_ctrl_o  : head entry; control reads zero when not valid
//   occupancy_o             : entries held (0..2)
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int CTRL_W    = DEF_CTRL_W
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [NUM_WORDS*WORD_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0]           in_ctrl_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [NUM_WORDS*WORD_W-1:0] out_data_o,
  output logic [CTRL_W-1:0]           out_ctrl_o,
  output logic [1:0]                  occupancy_o
);

  localparam int DATA_W  = NUM_WORDS * WORD_W;
  localparam int ENTRY_W = DATA_W + CTRL_W;

  state_e               state_d, state_q;
  logic                 in_ready_d, in_ready_q;
  logic                 push, pop;
  logic                 main_load, main_clr, main_from_skid;
  logic                 skid_load, skid_clr;
  logic [ENTRY_W-1:0]   in_entry, main_din, main_q, skid_q;

  assign in_entry = {in_ctrl_i, in_data_i};
  assign push     = in_valid_i & in_ready_q;
  assign pop      = (state_q != ST_EMPTY) & out_ready_i;

  // next state and slot controls; every path into EMPTY clears the main
  // slot so the outputs present a zero bubble without extra gating
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush_i) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end else begin
            state_d   = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end else if (push) begin
            skid_load = 1'b1;
            state_d   = ST_TWO;
          end else if (pop) begin
            main_clr  = 1'b1;
            state_d   = ST_EMPTY;
          end else begin
            state_d   = ST_ONE;
          end
        end
        ST_TWO: begin
          // in_ready_o is low here, so only the drain case exists
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = ST_ONE;
          end else begin
            state_d        = ST_TWO;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
    in_ready_d = (state_d != ST_TWO);
  end

  assign main_din = main_from_skid ? skid_q : in_entry;

  // state and ready registers; ready comes up one edge after reset release
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipe_slot #(.W(ENTRY_W)) u_main (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (main_load),
    .clr_i   (main_clr),
    .d_i     (main_din),
    .q_o     (main_q)
  );

  pipe_slot #(.W(ENTRY_W)) u_skid (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (skid_load),
    .clr_i   (skid_clr),
    .d_i     (in_entry),
    .q_o     (skid_q)
  );

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != ST_EMPTY);
  assign occupancy_o = state_q;
  assign out_data_o  = main_q[DATA_W-1:0];
  assign out_ctrl_o  = main_q[ENTRY_W-1:DATA_W];

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic plus a seeded random handshake run on
// a narrow instance checked against a queue scoreboard.
module tb_pipe_stage_elastic;

  logic         clk, rst_n, flush;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [159:0] in_data, out_data;
  logic [8:0]   in_ctrl, out_ctrl;
  logic [1:0]   occ;

  logic         r_in_valid, r_in_ready, r_out_valid, r_out_ready;
  logic [63:0]  r_in_data, r_out_data;
  logic [3:0]   r_in_ctrl, r_out_ctrl;
  logic [1:0]   r_occ;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_elastic dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_ctrl_i(in_ctrl),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_ctrl_o(out_ctrl), .occupancy_o(occ)
  );

  pipe_stage_elastic #(.NUM_WORDS(2), .CTRL_W(4)) dut_r (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(r_in_valid), .in_ready_o(r_in_ready),
    .in_data_i(r_in_data), .in_ctrl_i(r_in_ctrl),
    .out_valid_o(r_out_valid), .out_ready_i(r_out_ready),
    .out_data_o(r_out_data), .out_ctrl_o(r_out_ctrl), .occupancy_o(r_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // five distinct words: inst, pc, rs0, rs1, imm
  function automatic logic [159:0] mk(input logic [31:0] b);
    return {b + 32'd4, b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    r_in_valid = 1'b0; r_out_ready = 1'b0; r_in_data = '0; r_in_ctrl = '0;
    #2;
    n_cmp++; if ({out_valid, occ, in_ready, out_ctrl} !== 13'd0 || out_data !== 160'd0) begin
      n_err++; $display("FAIL reset_outputs got v=%0b occ=%0d rdy=%0b ctrl=%h want all zero", out_valid, occ, in_ready, out_ctrl); end
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_held got %0b want 0", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_rise got %0b want 1", in_ready); end
    n_cmp++; if (occ !== 2'd0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_empty got occ=%0d v=%0b want 0/0", occ, out_valid); end
  endtask

  task automatic test_single();
    @(negedge clk);
    in_valid = 1'b1; in_data = mk(32'h8C220004); in_ctrl = 9'h0A5; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || occ !== 2'd1) begin
      n_err++; $display("FAIL single_valid got v=%0b occ=%0d want 1/1", out_valid, occ); end
    n_cmp++; if (out_data !== mk(32'h8C220004)) begin
      n_err++; $display("FAIL single_data got %h want %h", out_data, mk(32'h8C220004)); end
    n_cmp++; if (out_ctrl !== 9'h0A5) begin n_err++; $display("FAIL single_ctrl got %h want 0a5", out_ctrl); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || occ !== 2'd0 || out_ctrl !== 9'h000) begin
      n_err++; $display("FAIL single_drain got v=%0b occ=%0d ctrl=%h want 0/0/000", out_valid, occ, out_ctrl); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'hA0000000); in_ctrl = 9'h011;
    @(negedge clk);
    in_data = mk(32'hB0000000); in_ctrl = 9'h022;
    @(negedge clk);
    in_data = mk(32'hC0000000); in_ctrl = 9'h033;
    n_cmp++; if (in_ready !== 1'b0 || occ !== 2'd2) begin
      n_err++; $display("FAIL b2b_full got rdy=%0b occ=%0d want 0/2", in_ready, occ); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (out_data !== mk(32'hA0000000) || out_ctrl !== 9'h011 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL b2b_stall_hold got %h/%h rdy=%0b want A/011/0", out_data[31:0], out_ctrl, in_ready); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_data !== mk(32'hB0000000) || out_ctrl !== 9'h022 || in_ready !== 1'b1 || occ !== 2'd1) begin
      n_err++; $display("FAIL b2b_second got %h/%h rdy=%0b occ=%0d want B/022/1/1", out_data[31:0], out_ctrl, in_ready, occ); end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_data !== mk(32'hC0000000) || out_ctrl !== 9'h033 || occ !== 2'd1) begin
      n_err++; $display("FAIL b2b_third got %h/%h occ=%0d want C/033/1", out_data[31:0], out_ctrl, occ); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || occ !== 2'd0) begin
      n_err++; $display("FAIL b2b_drain got v=%0b occ=%0d want 0/0", out_valid, occ); end
  endtask

  task automatic test_flush();
    // flush from TWO with an entry presented
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h11110000); in_ctrl = 9'h1FF;
    @(negedge clk);
    in_data = mk(32'h22220000);
    @(negedge clk);
    n_cmp++; if (occ !== 2'd2) begin n_err++; $display("FAIL flush_pre got occ=%0d want 2", occ); end
    flush = 1'b1; in_data = mk(32'hDDDD0000); out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (occ !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 9'h000 || out_data !== 160'd0) begin
      n_err++; $display("FAIL flush_two got occ=%0d v=%0b ctrl=%h want 0/0/000", occ, out_valid, out_ctrl); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %0b want 1", in_ready); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || occ !== 2'd0) begin
      n_err++; $display("FAIL flush_dropped got v=%0b occ=%0d want 0/0", out_valid, occ); end
    // flush from ONE with a ready-accepted entry presented: flush still wins
    in_valid = 1'b1; in_data = mk(32'h33330000); out_ready = 1'b0;
    @(negedge clk);
    flush = 1'b1; in_data = mk(32'h44440000);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || occ !== 2'd0 || out_ctrl !== 9'h000) begin
      n_err++; $display("FAIL flush_one got v=%0b occ=%0d ctrl=%h want 0/0/000", out_valid, occ, out_ctrl); end
  endtask

  task automatic test_stream();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = mk(32'h50000000); in_ctrl = 9'h0C3;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || occ !== 2'd1 || out_data !== mk(32'h50000000 + 32'(i - 1))) begin
        n_err++; $display("FAIL stream_%0d got v=%0b occ=%0d w0=%h want 1/1/%h", i, out_valid, occ, out_data[31:0], 32'h50000000 + 32'(i - 1)); end
      in_data = mk(32'h50000000 + 32'(i));
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_data !== mk(32'h50000064) || occ !== 2'd1) begin
      n_err++; $display("FAIL stream_last got w0=%h occ=%0d want 50000064/1", out_data[31:0], occ); end
    @(negedge clk);
    n_cmp++; if (occ !== 2'd0) begin n_err++; $display("FAIL stream_drain got occ=%0d want 0", occ); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h77770000); in_ctrl = 9'h155;
    @(negedge clk);
    in_data = mk(32'h88880000);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (occ !== 2'd2) begin n_err++; $display("FAIL areset_pre got occ=%0d want 2", occ); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || occ !== 2'd0 || in_ready !== 1'b0 || out_ctrl !== 9'h000 || out_data !== 160'd0) begin
      n_err++; $display("FAIL areset_async got v=%0b occ=%0d rdy=%0b ctrl=%h want all zero", out_valid, occ, in_ready, out_ctrl); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL areset_ready_early got %0b want 0", in_ready); end
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1 || occ !== 2'd0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL areset_release got rdy=%0b occ=%0d v=%0b want 1/0/0", in_ready, occ, out_valid); end
  endtask

  task automatic test_random();
    logic [67:0] q[$];
    logic        push, pop;
    void'($urandom(32'd1234));
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      n_cmp++; if (r_out_valid !== (q.size() != 0) || r_occ !== 2'(q.size()) || r_in_ready !== (q.size() < 2)) begin
        n_err++; $display("FAIL rand_state cyc %0d got v=%0b occ=%0d rdy=%0b want occ=%0d", c, r_out_valid, r_occ, r_in_ready, q.size()); end
      if (q.size() != 0) begin
        n_cmp++; if ({r_out_ctrl, r_out_data} !== q[0]) begin
          n_err++; $display("FAIL rand_data cyc %0d got %h want %h", c, {r_out_ctrl, r_out_data}, q[0]); end
      end else begin
        n_cmp++; if (r_out_ctrl !== 4'h0) begin n_err++; $display("FAIL rand_bubble cyc %0d got %h want 0", c, r_out_ctrl); end
      end
      r_in_valid  = 1'($urandom_range(0, 1));
      r_out_ready = 1'($urandom_range(0, 1));
      r_in_data   = {$urandom(), $urandom()};
      r_in_ctrl   = 4'($urandom_range(0, 15));
      pop  = (q.size() != 0) && r_out_ready;
      push = r_in_valid && (q.size() < 2);
      if (pop) void'(q.pop_front());
      if (push) q.push_back({r_in_ctrl, r_in_data});
    end
    @(negedge clk);
    r_in_valid = 1'b0; r_out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_stream();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
